// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and constants for the instruction-fetch / load-store memory arbiter.
package mem_access_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StRelease = 2'd2
    } arb_state_e;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_LH = 6'b100001;
    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SB = 6'b101000;

    localparam logic [5:0] FETCH_OP = 6'b100011;

    localparam int unsigned DEFAULT_TIMEOUT = 15;

    // A load/store command is legal only when the opcode class matches the write enable.
    function automatic logic ls_cmd_legal(input logic [5:0] op, input logic we);
        logic is_load;
        logic is_store;
        is_load  = (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
        is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
        return we ? is_store : is_load;
    endfunction

endpackage

// File: rtl/access_timer.sv
// Counts ACCESS-state cycles; flags the first cycle and the cycle on which the budget runs out.
module access_timer
    import mem_access_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic Clk,
    input  logic Clr,
    input  logic clear,
    input  logic enable,
    output logic first,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign first   = (count_q == '0);
    // Expires on the TIMEOUT-th ACCESS cycle, counting the first as number one.
    assign expired = (count_q == LastCnt);

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter granting one of fetch or load/store access to a single-port RAM,
// with command holding registers, stale-MOC filtering and an access timeout.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        Clk,
    input  logic        Clr,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [5:0]  ls_op,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_done,
    output logic [31:0] ls_rdata,

    output logic        MOV,
    output logic        RW,
    output logic [5:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        MOC,
    input  logic [31:0] mem_rdata,

    output logic        busy,
    output logic        err
);

    arb_state_e  state_q;
    logic        prio_ls_q;
    logic        owner_ls_q;
    logic        hold_rw_q;
    logic [5:0]  hold_op_q;
    logic [31:0] hold_addr_q;
    logic [31:0] hold_wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] ls_rdata_q;
    logic        if_done_q;
    logic        ls_done_q;
    logic        err_q;
    logic        busy_q;
    logic        mov_q;

    logic        grant;
    logic        pick_ls;
    logic        ls_legal;
    logic        tmr_first;
    logic        tmr_expired;
    logic        moc_ok;
    logic        finish;
    logic [31:0] rel_rdata;

    access_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_access_timer (
        .Clk     (Clk),
        .Clr     (Clr),
        .clear   (state_q != StAccess),
        .enable  (state_q == StAccess),
        .first   (tmr_first),
        .expired (tmr_expired)
    );

    always_comb begin
        // ls wins a tie when the priority bit points at it; otherwise whoever asks alone.
        pick_ls   = ls_req && (!if_req || prio_ls_q);
        grant     = (state_q == StIdle) && (if_req || ls_req);
        ls_legal  = ls_cmd_legal(ls_op, ls_we);
        // A MOC still high from the previous access is not trusted in the first cycle.
        moc_ok    = MOC && !tmr_first;
        finish    = (state_q == StAccess) && (moc_ok || tmr_expired);
        rel_rdata = (moc_ok && hold_rw_q) ? mem_rdata : 32'h0;
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q      <= StIdle;
            prio_ls_q    <= 1'b1;
            owner_ls_q   <= 1'b0;
            hold_rw_q    <= 1'b1;
            hold_op_q    <= 6'h0;
            hold_addr_q  <= 32'h0;
            hold_wdata_q <= 32'h0;
            if_rdata_q   <= 32'h0;
            ls_rdata_q   <= 32'h0;
            if_done_q    <= 1'b0;
            ls_done_q    <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            mov_q        <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            err_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        owner_ls_q <= pick_ls;
                        prio_ls_q  <= !pick_ls;
                        busy_q     <= 1'b1;
                        if (pick_ls) begin
                            hold_rw_q    <= !ls_we;
                            hold_op_q    <= ls_op;
                            hold_addr_q  <= ls_addr;
                            hold_wdata_q <= ls_we ? ls_wdata : 32'h0;
                            if (ls_legal) begin
                                state_q <= StAccess;
                                mov_q   <= 1'b1;
                            end else begin
                                state_q    <= StRelease;
                                ls_done_q  <= 1'b1;
                                err_q      <= 1'b1;
                                ls_rdata_q <= 32'h0;
                            end
                        end else begin
                            hold_rw_q    <= 1'b1;
                            hold_op_q    <= FETCH_OP;
                            hold_addr_q  <= if_addr;
                            hold_wdata_q <= 32'h0;
                            state_q      <= StAccess;
                            mov_q        <= 1'b1;
                        end
                    end
                end
                StAccess: begin
                    if (finish) begin
                        state_q <= StRelease;
                        mov_q   <= 1'b0;
                        err_q   <= !moc_ok;
                        if (owner_ls_q) begin
                            ls_done_q  <= 1'b1;
                            ls_rdata_q <= rel_rdata;
                        end else begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= rel_rdata;
                        end
                    end
                end
                StRelease: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    mov_q   <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt    = grant && !pick_ls;
    assign ls_gnt    = grant && pick_ls;
    assign if_done   = if_done_q;
    assign ls_done   = ls_done_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign MOV       = mov_q;
    assign RW        = hold_rw_q;
    assign mem_op    = hold_op_q;
    assign mem_addr  = hold_addr_q;
    assign mem_wdata = hold_wdata_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench: tests push expected completions, a monitor pops and checks them on done.
module tb_mem_access_arbiter;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [5:0]  ls_op;
    logic        if_gnt, if_done, ls_gnt, ls_done;
    logic [31:0] if_rdata, ls_rdata;
    logic        MOV, RW, MOC, busy, err;
    logic [5:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit          is_ls;
        logic        rw;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          mov;
    } exp_t;

    exp_t exp_q[$];

    int moc_at   = 0;
    bit moc_hold = 1'b0;
    int acc_k    = 0;
    int mov_cnt  = 0;

    mem_access_arbiter #(.TIMEOUT(15)) dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_op     (ls_op),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .MOV       (MOV),
        .RW        (RW),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .MOC       (MOC),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .err       (err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h11223344;
            32'h40:  return 32'hDEADBEEF;
            32'h80:  return 32'hCAFEF00D;
            default: return a ^ 32'h5A5A5A5A;
        endcase
    endfunction

    // RAM model: MOC rises on ACCESS cycle moc_at (0 = never); moc_hold forces a stuck-high MOC.
    always @(negedge Clk) begin
        if (MOV) begin
            acc_k++;
            MOC       = ((moc_at != 0) && (acc_k >= moc_at)) || moc_hold;
            mem_rdata = mem_word(mem_addr);
        end else begin
            acc_k = 0;
            MOC   = moc_hold;
        end
    end

    // Monitor: checks command fields during MOV and pops one expectation per done pulse.
    always @(posedge Clk) begin
        #1;
        if (!Clr) begin
            mov_cnt = 0;
        end else begin
            if (MOV) begin
                mov_cnt++;
                if (exp_q.size() == 0) begin
                    check("mov_unexpected", 32'(MOV), 32'h0);
                end else begin
                    check("mem_rw", 32'(RW), 32'(exp_q[0].rw));
                    check("mem_op", 32'(mem_op), 32'(exp_q[0].op));
                    check("mem_addr", mem_addr, exp_q[0].addr);
                    if (!exp_q[0].rw) check("mem_wdata", mem_wdata, exp_q[0].wdata);
                end
            end
            if (if_done || ls_done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", {30'h0, if_done, ls_done}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_owner_ls", 32'(ls_done), 32'(e.is_ls));
                    check("done_owner_if", 32'(if_done), 32'(!e.is_ls));
                    check("rdata", e.is_ls ? ls_rdata : if_rdata, e.rdata);
                    check("err", 32'(err), 32'(e.err));
                    check("mov_cycles", 32'(mov_cnt), 32'(e.mov));
                end
                mov_cnt = 0;
            end
        end
    end

    task automatic push_exp(input bit is_ls, input logic rw, input logic [5:0] op,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic e_err, input int mov);
        exp_t e;
        e.is_ls = is_ls; e.rw = rw; e.op = op; e.addr = addr; e.wdata = wdata;
        e.rdata = rdata; e.err = e_err; e.mov = mov;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input bit is_ls);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge Clk);
            #1;
            seen = is_ls ? ls_done : if_done;
        end
        check(is_ls ? "ls_done_timeout" : "if_done_timeout", 32'(seen), 32'h1);
        if (is_ls) ls_req = 1'b0;
        else if_req = 1'b0;
    endtask

    task automatic issue_if(input logic [31:0] addr);
        @(negedge Clk);
        if_req  = 1'b1;
        if_addr = addr;
        wait_done(1'b0);
    endtask

    task automatic issue_ls(input logic we, input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata);
        @(negedge Clk);
        ls_req = 1'b1; ls_we = we; ls_op = op; ls_addr = addr; ls_wdata = wdata;
        wait_done(1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        Clr = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_op = 6'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
        MOC = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge Clk);
        check("rst_mov", 32'(MOV), 32'h0);
        check("rst_rw", 32'(RW), 32'h1);
        check("rst_op", 32'(mem_op), 32'h0);
        check("rst_flags", {26'h0, if_gnt, ls_gnt, if_done, ls_done, busy, err}, 32'h0);
        Clr = 1'b1;

        // Fetch only, exact cycle timing.
        moc_at = 2;
        push_exp(1'b0, 1'b1, 6'b100011, 32'h10, 32'h0, 32'h11223344, 1'b0, 2);
        @(negedge Clk);
        if_req = 1'b1; if_addr = 32'h10;
        #1 check("fetch_gnt_c0", {30'h0, if_gnt, MOV}, 32'h2);
        @(posedge Clk); #1 check("fetch_mov_c1", {30'h0, MOV, busy}, 32'h3);
        @(posedge Clk); #1 check("fetch_mov_c2", {30'h0, MOV, if_done}, 32'h2);
        @(posedge Clk); #1 check("fetch_done_c3", {29'h0, if_done, MOV, busy}, 32'h5);
        if_req = 1'b0;
        @(posedge Clk); #1 check("fetch_idle_c4", {30'h0, busy, if_done}, 32'h0);

        // Contention after reset: ls first, fetch right after RELEASE, then ls again.
        push_exp(1'b1, 1'b1, 6'b100011, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        push_exp(1'b0, 1'b1, 6'b100011, 32'h80, 32'h0, 32'hCAFEF00D, 1'b0, 2);
        @(negedge Clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_op = 6'b100011; ls_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h80;
        #1 check("contend1_gnt", {30'h0, ls_gnt, if_gnt}, 32'h2);
        wait_done(1'b1);
        @(posedge Clk); #1 check("contend1_if_gnt_after", {30'h0, ls_gnt, if_gnt}, 32'h1);
        wait_done(1'b0);
        push_exp(1'b1, 1'b1, 6'b100001, 32'h44, 32'h0, 32'h5A5A5A1E, 1'b0, 2);
        push_exp(1'b0, 1'b1, 6'b100011, 32'h84, 32'h0, 32'h5A5A5ADE, 1'b0, 2);
        repeat (2) @(negedge Clk);
        ls_req = 1'b1; ls_op = 6'b100001; ls_addr = 32'h44;
        if_req = 1'b1; if_addr = 32'h84;
        #1 check("contend2_gnt", {30'h0, ls_gnt, if_gnt}, 32'h2);
        wait_done(1'b1);
        wait_done(1'b0);

        // Store halfword; fetch data must hold across an ls completion.
        moc_at = 3;
        push_exp(1'b1, 1'b0, 6'b101001, 32'h20, 32'hABCD, 32'h0, 1'b0, 3);
        issue_ls(1'b1, 6'b101001, 32'h20, 32'h0000ABCD);
        check("store_ls_rdata", ls_rdata, 32'h0);
        check("if_rdata_hold", if_rdata, 32'h5A5A5ADE);

        // Stale MOC stuck high: first ACCESS cycle must not complete.
        moc_at = 0; moc_hold = 1'b1;
        push_exp(1'b0, 1'b1, 6'b100011, 32'h10, 32'h0, 32'h11223344, 1'b0, 2);
        issue_if(32'h10);
        moc_hold = 1'b0;

        // Timeout with MOC never asserted.
        moc_at = 0;
        push_exp(1'b1, 1'b1, 6'b100000, 32'h40, 32'h0, 32'h0, 1'b1, 15);
        issue_ls(1'b0, 6'b100000, 32'h40, 32'h0);

        // Illegal opcode and we/op mismatch: err without MOV.
        push_exp(1'b1, 1'b1, 6'h3F, 32'h60, 32'h0, 32'h0, 1'b1, 0);
        issue_ls(1'b0, 6'h3F, 32'h60, 32'h0);
        push_exp(1'b1, 1'b0, 6'b100011, 32'h64, 32'h1234, 32'h0, 1'b1, 0);
        issue_ls(1'b1, 6'b100011, 32'h64, 32'h1234);

        // Reset mid-ACCESS: MOV drops at once, no done.
        moc_at = 0;
        push_exp(1'b0, 1'b1, 6'b100011, 32'h88, 32'h0, 32'h0, 1'b0, 0);
        repeat (2) @(negedge Clk);
        if_req = 1'b1; if_addr = 32'h88;
        @(posedge Clk); #1 check("abort_mov_before", 32'(MOV), 32'h1);
        #2 Clr = 1'b0;
        #1 check("abort_mov_async", 32'(MOV), 32'h0);
        check("abort_flags", {28'h0, if_done, ls_done, busy, err}, 32'h0);
        check("abort_rw_addr", {RW, mem_addr[30:0]}, 32'h80000000);
        check("abort_rdata", if_rdata | ls_rdata, 32'h0);
        exp_q.delete(0);
        if_req = 1'b0;
        repeat (2) @(negedge Clk);
        check("abort_no_done", {30'h0, if_done, ls_done}, 32'h0);
        Clr = 1'b1;

        moc_at = 2;
        push_exp(1'b1, 1'b1, 6'b100011, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        issue_ls(1'b0, 6'b100011, 32'h40, 32'h0);

        repeat (4) @(negedge Clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
